// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word-aligned fetch at a time and
// buffers returned words with their PCs for decode. Redirects flush the buffer and drop stale responses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_HALT
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic               drop;
  logic               req_q;
  logic               fault_q;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [31:0]        fifo_instr [FIFO_DEPTH];

  logic push;
  logic pop;
  logic aligned;
  logic rsp_pending;
  logic room_next;

  assign imem_req    = req_q;
  assign imem_addr   = {pc[31:2], 2'b00};
  assign fetch_fault = fault_q;
  assign out_valid   = (count != '0);
  assign out_instr   = out_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign out_pc      = out_valid ? fifo_pc[rd_ptr]    : 32'h0;

  assign aligned = (redirect_pc[1:0] == 2'b00);
  assign push    = (state == ST_WAIT) && imem_rvalid && !drop && !redirect_valid;
  assign pop     = out_valid && out_ready && !redirect_valid;

  // A response is still owed if a request is on the bus now or was issued and has not returned yet.
  assign rsp_pending = req_q
                     || ((state == ST_WAIT) && !imem_rvalid)
                     || ((state == ST_HALT) && drop && !imem_rvalid);

  always_comb begin
    count_next = count;
    if (redirect_valid) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  assign room_next = (count_next < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ISSUE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      count <= count_next;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        pc     <= redirect_pc;
        drop   <= rsp_pending;
        if (aligned) begin
          fault_q <= 1'b0;
          // An owed response must drain before a new request may go out.
          if (rsp_pending) begin
            state <= ST_WAIT;
            req_q <= 1'b0;
          end else begin
            state <= ST_ISSUE;
            req_q <= room_next;
          end
        end else begin
          fault_q <= 1'b1;
          state   <= ST_HALT;
          req_q   <= 1'b0;
        end
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case (state)
          ST_ISSUE: begin
            if (req_q) begin
              state <= ST_WAIT;
              req_q <= 1'b0;
            end else begin
              req_q <= room_next;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid) begin
              if (!drop) begin
                pc <= pc + 32'd4;
              end
              drop  <= 1'b0;
              state <= ST_ISSUE;
              req_q <= room_next;
            end
          end
          ST_HALT: begin
            req_q <= 1'b0;
            if (imem_rvalid) begin
              drop <= 1'b0;
            end
          end
          default: begin
            state <= ST_ISSUE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a simple memory responder plus a linear cycle-by-cycle script.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        fetch_fault;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr = 32'h0;
  int          cd = 0;
  logic [31:0] rsp_addr = 32'h0;
  int          nreq;
  logic [31:0] req_addrs [2];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Memory model: answers each request after 'lat' cycles, optionally with a forced word.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ovr_en ? ovr : memWord(rsp_addr);
        end
      end
      if (imem_req) begin
        cd       = lat;
        rsp_addr = imem_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
    checkOutput("rst_pc", out_pc, 32'h0);
    checkOutput("rst_instr", out_instr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Streaming fetch with a one-cycle memory and decode always ready
    tick();
    checkOutput("t1_req0", 32'(imem_req), 32'd1);
    checkOutput("t1_addr0", imem_addr, 32'h0);
    checkOutput("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t1_wait_req", 32'(imem_req), 32'd0);
    checkOutput("t1_wait_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t1_valid0", 32'(out_valid), 32'd1);
    checkOutput("t1_pc0", out_pc, 32'h0);
    checkOutput("t1_instr0", out_instr, memWord(32'h0));
    checkOutput("t1_req1", 32'(imem_req), 32'd1);
    checkOutput("t1_addr1", imem_addr, 32'h4);
    tick();
    checkOutput("t1_popped", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t1_pc1", out_pc, 32'h4);
    checkOutput("t1_instr1", out_instr, memWord(32'h4));
    checkOutput("t1_addr2", imem_addr, 32'h8);
    tick();
    tick();
    checkOutput("t1_pc2", out_pc, 32'h8);
    checkOutput("t1_instr2", out_instr, memWord(32'h8));

    // Back-pressure: buffer fills after two fetches and requests stop
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (imem_req) begin
        if (nreq < 2) req_addrs[nreq] = imem_addr;
        nreq++;
      end
    end
    checkOutput("t2_nreq", 32'(nreq), 32'd2);
    checkOutput("t2_addr0", req_addrs[0], 32'h0);
    checkOutput("t2_addr1", req_addrs[1], 32'h4);
    checkOutput("t2_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_hold_pc", out_pc, 32'h0);
    checkOutput("t2_hold_instr", out_instr, memWord(32'h0));
    lat    = 2;
    ovr_en = 1'b1;
    ovr    = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t2_pc1", out_pc, 32'h4);
    checkOutput("t2_instr1", out_instr, memWord(32'h4));
    checkOutput("t2_resume_req", 32'(imem_req), 32'd1);
    checkOutput("t2_resume_addr", imem_addr, 32'h8);

    // Redirect while waiting on addr 8; its late DEADBEEF response must be dropped
    tick();
    checkOutput("t3_empty", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t3_no_req", 32'(imem_req), 32'd0);
    checkOutput("t3_flushed", 32'(out_valid), 32'd0);
    tick();
    lat    = 1;
    ovr_en = 1'b0;
    checkOutput("t3_req", 32'(imem_req), 32'd1);
    checkOutput("t3_addr", imem_addr, 32'h40);
    checkOutput("t3_dropped", 32'(out_valid), 32'd0);
    tick();
    tick();
    checkOutput("t3_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_pc", out_pc, 32'h40);
    checkOutput("t3_instr", out_instr, memWord(32'h40));
    checkOutput("t3_next_addr", imem_addr, 32'h44);

    // Redirect coinciding with the response for 0x44
    tick();
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t4_flushed", 32'(out_valid), 32'd0);
    checkOutput("t4_req", 32'(imem_req), 32'd1);
    checkOutput("t4_addr", imem_addr, 32'h80);
    tick();
    checkOutput("t4_no_stale", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t4_valid", 32'(out_valid), 32'd1);
    checkOutput("t4_pc", out_pc, 32'h80);
    checkOutput("t4_instr", out_instr, memWord(32'h80));
    checkOutput("t4_next_addr", imem_addr, 32'h84);

    // Misaligned redirect halts fetch; an aligned one restarts it
    applyStimulus(1'b0, 1'b1, 32'h102, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t5_fault", 32'(fetch_fault), 32'd1);
    checkOutput("t5_req", 32'(imem_req), 32'd0);
    checkOutput("t5_flushed", 32'(out_valid), 32'd0);
    checkOutput("t5_addr_aligned", 32'(imem_addr[1:0]), 32'd0);
    nreq = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_req) nreq++;
    end
    checkOutput("t5_halt_nreq", 32'(nreq), 32'd0);
    checkOutput("t5_halt_fault", 32'(fetch_fault), 32'd1);
    checkOutput("t5_halt_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    checkOutput("t5_fault_clr", 32'(fetch_fault), 32'd0);
    checkOutput("t5_req_resume", 32'(imem_req), 32'd1);
    checkOutput("t5_addr_resume", imem_addr, 32'h100);

    // Redirect on the request cycle of 0x100, then wrap past the top of memory
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_wait_req", 32'(imem_req), 32'd0);
    checkOutput("t6_wait_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("t6_req_top", 32'(imem_req), 32'd1);
    checkOutput("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    checkOutput("t6_no_stale", 32'(out_valid), 32'd0);
    tick();
    tick();
    checkOutput("t6_valid_top", 32'(out_valid), 32'd1);
    checkOutput("t6_pc_top", out_pc, 32'hFFFF_FFFC);
    checkOutput("t6_instr_top", out_instr, memWord(32'hFFFF_FFFC));
    checkOutput("t6_req_wrap", 32'(imem_req), 32'd1);
    checkOutput("t6_addr_wrap", imem_addr, 32'h0);
    tick();
    checkOutput("t6_inwait", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t6_rst_req", 32'(imem_req), 32'd0);
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_fault", 32'(fetch_fault), 32'd0);
    checkOutput("t6_rst_pc", out_pc, 32'h0);
    checkOutput("t6_rst_instr", out_instr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t6_post_req", 32'(imem_req), 32'd1);
    checkOutput("t6_post_addr", imem_addr, 32'h0);
    checkOutput("t6_post_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
